// File: rtl/greyhound_boot_pkg.sv
// Shared types and default parameters for the greyhound boot/pad-conditioning
// stage. The boot_state_e encoding is visible on boot_state_o, so its values
// are fixed.
package greyhound_boot_pkg;

  localparam int unsigned DEF_NUM_GPIOS       = 32;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
  localparam int unsigned DEF_CFG_GRACE       = 4;
  localparam int unsigned DEF_CFG_TIMEOUT     = 1024;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 8;

  typedef enum logic [2:0] {
    BOOT_HOLD     = 3'd0,
    BOOT_STRAP    = 3'd1,
    BOOT_CFG_WAIT = 3'd2,
    BOOT_RUN      = 3'd3,
    BOOT_ERROR    = 3'd4
  } boot_state_e;

endpackage

// File: rtl/greyhound_debounce.sv
// One-bit debouncer with its own input synchroniser.
// The synchronised input must differ from the held value for DEBOUNCE_CYCLES
// consecutive cycles before the held value flips.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset (the synchronised boot reset)
//   d_i    - raw asynchronous input
//   q_o    - debounced value, registered
module greyhound_debounce
  import greyhound_boot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   fe_db_q;
  logic                   d_sync;

  assign d_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every clocked assignment is non-blocking so all flops sample the
  // pre-edge values; blocking here would collapse the synchroniser stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      fe_db_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      if (d_sync == fe_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        fe_db_q <= ~fe_db_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign q_o = fe_db_q;

endmodule

// File: rtl/greyhound_boot_ctrl.sv
// Boot controller and pad-input conditioning in front of the greyhound core.
// Synchronises the pad reset (async assert, sync release), holds the core in
// reset, latches the fpga_mode strap once, waits for configuration to finish
// and then passes a debounced fetch enable. GPIO inputs are synchronised.
// Ports:
//   clk_i, rst_ni       - clock and raw asynchronous active-low pad reset
//   fpga_mode_pad_i     - raw strap pad
//   fetch_enable_pad_i  - raw fetch-enable pad
//   gpio_pad_i          - raw GPIO pads
//   config_busy_i       - configuration busy, already in clk_i domain
//   core_rst_no         - active-low core reset
//   fpga_mode_o         - latched strap
//   fetch_enable_o      - debounced fetch enable, only in RUN
//   gpio_sync_o         - synchronised GPIOs
//   boot_state_o        - current boot state
//   boot_done_o         - high in RUN
//   config_timeout_o    - high in ERROR (terminal until reset)
module greyhound_boot_ctrl
  import greyhound_boot_pkg::*;
#(
  parameter int unsigned NUM_GPIOS       = DEF_NUM_GPIOS,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned CFG_GRACE       = DEF_CFG_GRACE,
  parameter int unsigned CFG_TIMEOUT     = DEF_CFG_TIMEOUT,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fpga_mode_pad_i,
  input  logic                 fetch_enable_pad_i,
  input  logic [NUM_GPIOS-1:0] gpio_pad_i,
  input  logic                 config_busy_i,
  output logic                 core_rst_no,
  output logic                 fpga_mode_o,
  output logic                 fetch_enable_o,
  output logic [NUM_GPIOS-1:0] gpio_sync_o,
  output logic [2:0]           boot_state_o,
  output logic                 boot_done_o,
  output logic                 config_timeout_o
);

  localparam int unsigned HOLD_W     = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int unsigned CFG_W      = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT) : 1;
  localparam int unsigned GRACE_LAST = (CFG_GRACE > 0) ? CFG_GRACE - 1 : 0;

  // Reset synchroniser: assert follows rst_ni at once, release waits for
  // SYNC_STAGES clock edges.
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_sync_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  // Strap and GPIO synchronisers run straight off the pad reset so the strap
  // is already settled by the time the FSM reaches STRAP.
  logic [SYNC_STAGES-1:0]                strap_sync_q;
  logic [SYNC_STAGES-1:0][NUM_GPIOS-1:0] gpio_sync_q;
  logic                                  strap_sync;

  // NOTE: the synchroniser chains are reset as well so gpio_sync_o reads 0 in
  // reset instead of whatever the pads happened to hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strap_sync_q <= '0;
      gpio_sync_q  <= '0;
    end else begin
      strap_sync_q <= {strap_sync_q[SYNC_STAGES-2:0], fpga_mode_pad_i};
      gpio_sync_q  <= {gpio_sync_q[SYNC_STAGES-2:0], gpio_pad_i};
    end
  end

  assign strap_sync  = strap_sync_q[SYNC_STAGES-1];
  assign gpio_sync_o = gpio_sync_q[SYNC_STAGES-1];

  // Boot FSM
  boot_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CFG_W-1:0]  cfg_cnt_q, cfg_cnt_d;
  logic              fpga_mode_q, fpga_mode_d;
  logic              core_rst_q;

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cfg_cnt_d   = cfg_cnt_q;
    fpga_mode_d = fpga_mode_q;
    unique case (state_q)
      BOOT_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD_CYCLES - 1)) state_d = BOOT_STRAP;
        else                                            hold_cnt_d = hold_cnt_q + 1'b1;
      end
      BOOT_STRAP: begin
        fpga_mode_d = strap_sync;
        cfg_cnt_d   = '0;
        state_d     = BOOT_CFG_WAIT;
      end
      BOOT_CFG_WAIT: begin
        // Completion is checked first so it wins over a same-edge timeout.
        if (cfg_cnt_q >= CFG_W'(GRACE_LAST) && !config_busy_i) state_d = BOOT_RUN;
        else if (cfg_cnt_q == CFG_W'(CFG_TIMEOUT - 1))         state_d = BOOT_ERROR;
        else                                                   cfg_cnt_d = cfg_cnt_q + 1'b1;
      end
      default: ;  // RUN and ERROR are terminal
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= BOOT_HOLD;
      hold_cnt_q  <= '0;
      cfg_cnt_q   <= '0;
      fpga_mode_q <= 1'b0;
      core_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cfg_cnt_q   <= cfg_cnt_d;
      fpga_mode_q <= fpga_mode_d;
      // Registered from the next state so it rises on the STRAP exit edge.
      core_rst_q  <= (state_d == BOOT_CFG_WAIT) || (state_d == BOOT_RUN) ||
                     (state_d == BOOT_ERROR);
    end
  end

  // Fetch enable: debounced continuously from reset release, gated by RUN.
  logic fe_db;

  greyhound_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_fetch_debounce (
    .clk_i (clk_i),
    .rst_ni(rst_sync_n),
    .d_i   (fetch_enable_pad_i),
    .q_o   (fe_db)
  );

  assign core_rst_no      = core_rst_q;
  assign fpga_mode_o      = fpga_mode_q;
  assign boot_state_o     = state_q;
  assign boot_done_o      = (state_q == BOOT_RUN);
  assign config_timeout_o = (state_q == BOOT_ERROR);
  assign fetch_enable_o   = fe_db & (state_q == BOOT_RUN);

endmodule
